// File: rtl/obf_pkg.sv
// Shared definitions for the obfuscated-core unlock controller:
// default geometry and the controller state encoding.
package obf_pkg;

   localparam int unsigned DEF_KEY_LEN   = 5;
   localparam int unsigned DEF_RST_CYC   = 2;
   localparam int unsigned DEF_MAX_TRIES = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RST_CORE = 3'd1,
      ST_SHIFT    = 3'd2,
      ST_PASS     = 3'd3,
      ST_LOCKOUT  = 3'd4
   } obf_state_e;

endpackage

// File: rtl/obf_key_shifter.sv
// Loadable MSB-first key shift register with a bit counter; o_done flags
// the cycle on which the last key bit is presented.
module obf_key_shifter
   import obf_pkg::*;
#(
   parameter int unsigned KEY_LEN = DEF_KEY_LEN
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic [KEY_LEN-1:0] i_key,
   input  logic               i_shift,
   input  logic               i_clear,
   output logic               o_bit,
   output logic               o_done
);

   localparam int unsigned CW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(KEY_LEN - 1);

   logic [KEY_LEN-1:0] r_sreg;
   logic [CW-1:0]      r_idx;

   // Key register and shift index; clear wins over load so an aborted attempt leaves nothing behind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sreg <= '0;
         r_idx  <= '0;
      end else if (i_clear) begin
         r_sreg <= '0;
         r_idx  <= '0;
      end else if (i_load) begin
         r_sreg <= i_key;
         r_idx  <= '0;
      end else if (i_shift) begin
         r_sreg <= r_sreg << 1;
         r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + CW'(1);
      end else begin
         r_sreg <= r_sreg;
         r_idx  <= r_idx;
      end
   end

   assign o_bit  = r_sreg[KEY_LEN-1];
   assign o_done = i_shift && (r_idx == LAST_IDX);

endmodule

// File: rtl/obf_unlock_ctrl.sv
// Unlock controller for an obfuscated FSM core: resets the core, shifts the
// unlock key in, then connects the user path; rate-limited by an attempt counter.
module obf_unlock_ctrl
   import obf_pkg::*;
#(
   parameter int unsigned KEY_LEN   = DEF_KEY_LEN,
   parameter int unsigned RST_CYC   = DEF_RST_CYC,
   parameter int unsigned MAX_TRIES = DEF_MAX_TRIES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [KEY_LEN-1:0] key_in,
   input  logic               relock,
   input  logic               user_x,
   input  logic               fsm_out,
   output logic               obf_rst_n,
   output logic               fsm_x,
   output logic               user_out,
   output logic               busy,
   output logic               unlocked,
   output logic               lockout
);

   localparam int unsigned TW = $clog2(MAX_TRIES + 1);
   localparam int unsigned RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);
   localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYC - 1);

   obf_state_e  r_state;
   logic [TW-1:0] r_tries;
   logic [RW-1:0] r_rst_cnt;
   logic        r_obf_rst_n;
   logic        r_busy;
   logic        r_unlocked;
   logic        r_lockout;

   logic        w_accept;
   logic        w_shift;
   logic        w_clear;
   logic        w_key_bit;
   logic        w_done;

   // Shifter control decoded from the current state; relock pre-empts everything.
   always_comb begin
      w_accept = (r_state == ST_IDLE) && start && !relock && (r_tries < TRIES_MAX);
      w_shift  = (r_state == ST_SHIFT) && !relock;
      w_clear  = relock && ((r_state == ST_RST_CORE) || (r_state == ST_SHIFT) ||
                            (r_state == ST_PASS));
   end

   obf_key_shifter #(
      .KEY_LEN (KEY_LEN)
   ) u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_accept),
      .i_key   (key_in),
      .i_shift (w_shift),
      .i_clear (w_clear),
      .o_bit   (w_key_bit),
      .o_done  (w_done)
   );

   // Controller FSM with its registered outputs and saturating attempt counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_tries     <= '0;
         r_rst_cnt   <= '0;
         r_obf_rst_n <= 1'b1;
         r_busy      <= 1'b0;
         r_unlocked  <= 1'b0;
         r_lockout   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_busy     <= 1'b0;
               r_unlocked <= 1'b0;
               r_lockout  <= 1'b0;
               if (relock) begin
                  r_obf_rst_n <= 1'b1;
               end else if (start) begin
                  if (r_tries < TRIES_MAX) begin
                     r_state     <= ST_RST_CORE;
                     r_tries     <= (r_tries == TRIES_MAX) ? r_tries : r_tries + TW'(1);
                     r_rst_cnt   <= '0;
                     r_obf_rst_n <= 1'b0;
                     r_busy      <= 1'b1;
                  end else begin
                     r_state     <= ST_LOCKOUT;
                     r_obf_rst_n <= 1'b0;
                     r_lockout   <= 1'b1;
                  end
               end else begin
                  r_obf_rst_n <= 1'b1;
               end
            end
            ST_RST_CORE: begin
               if (relock) begin
                  r_state     <= ST_IDLE;
                  r_obf_rst_n <= 1'b0;
                  r_busy      <= 1'b0;
                  r_rst_cnt   <= '0;
               end else if (r_rst_cnt == RST_LAST) begin
                  r_state     <= ST_SHIFT;
                  r_obf_rst_n <= 1'b1;
                  r_rst_cnt   <= '0;
               end else begin
                  r_rst_cnt   <= r_rst_cnt + RW'(1);
               end
            end
            ST_SHIFT: begin
               if (relock) begin
                  r_state     <= ST_IDLE;
                  r_obf_rst_n <= 1'b0;
                  r_busy      <= 1'b0;
               end else if (w_done) begin
                  r_state     <= ST_PASS;
                  r_busy      <= 1'b0;
                  r_unlocked  <= 1'b1;
               end else begin
                  r_state     <= ST_SHIFT;
               end
            end
            ST_PASS: begin
               if (relock) begin
                  r_state     <= ST_IDLE;
                  r_obf_rst_n <= 1'b0;
                  r_unlocked  <= 1'b0;
               end else begin
                  r_state     <= ST_PASS;
               end
            end
            ST_LOCKOUT: begin
               r_state     <= ST_LOCKOUT;
               r_obf_rst_n <= 1'b0;
               r_busy      <= 1'b0;
               r_unlocked  <= 1'b0;
               r_lockout   <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_obf_rst_n <= 1'b1;
               r_busy      <= 1'b0;
               r_unlocked  <= 1'b0;
               r_lockout   <= 1'b0;
            end
         endcase
      end
   end

   // Only the core-facing serial input and the user return path are combinational.
   always_comb begin
      fsm_x    = 1'b0;
      user_out = 1'b0;
      case (r_state)
         ST_SHIFT: begin
            fsm_x    = w_key_bit;
            user_out = 1'b0;
         end
         ST_PASS: begin
            fsm_x    = user_x;
            user_out = fsm_out;
         end
         default: begin
            fsm_x    = 1'b0;
            user_out = 1'b0;
         end
      endcase
   end

   assign obf_rst_n = r_obf_rst_n;
   assign busy      = r_busy;
   assign unlocked  = r_unlocked;
   assign lockout   = r_lockout;

endmodule

// File: tb/tb_obf_unlock_ctrl.sv
// Self-checking bench for obf_unlock_ctrl: timeline-based reference model
// compared every cycle, plus directed literal checks.
module tb_obf_unlock_ctrl;

   localparam int KL = 5;
   localparam int RC = 2;
   localparam int MT = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          relock = 1'b0;
   logic          user_x = 1'b0;
   logic          fsm_out = 1'b0;
   logic [KL-1:0] key_in = '0;
   logic          obf_rst_n, fsm_x, user_out, busy, unlocked, lockout;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   obf_unlock_ctrl #(.KEY_LEN(KL), .RST_CYC(RC), .MAX_TRIES(MT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key_in    (key_in),
      .relock    (relock),
      .user_x    (user_x),
      .fsm_out   (fsm_out),
      .obf_rst_n (obf_rst_n),
      .fsm_x     (fsm_x),
      .user_out  (user_out),
      .busy      (busy),
      .unlocked  (unlocked),
      .lockout   (lockout)
   );

   // Reference model: mode 0 idle, 1 attempt running, 2 locked out.
   // During an attempt, outputs follow from the cycle count since the accepting edge.
   int            edges = 0;
   int            m_mode = 0;
   int            m_t0 = 0;
   int            m_tries = 0;
   bit            m_pulse = 1'b0;
   logic [KL-1:0] m_key = '0;
   bit            chk_en = 1'b0;

   always @(posedge clk) begin
      edges  <= edges + 1;
      chk_en <= 1'b1;
      if (!rst_n) begin
         m_mode  <= 0;
         m_tries <= 0;
         m_pulse <= 1'b0;
         m_key   <= '0;
      end else begin
         case (m_mode)
            0: begin
               m_pulse <= 1'b0;
               if (start && !relock) begin
                  if (m_tries < MT) begin
                     m_mode  <= 1;
                     m_tries <= m_tries + 1;
                     m_key   <= key_in;
                     m_t0    <= edges + 1;
                  end else begin
                     m_mode <= 2;
                  end
               end
            end
            1: begin
               if (relock) begin
                  m_mode  <= 0;
                  m_pulse <= 1'b1;
               end
            end
            default: begin
               m_mode <= m_mode;
            end
         endcase
      end
   end

   function automatic logic [5:0] outs();
      return {obf_rst_n, fsm_x, user_out, busy, unlocked, lockout};
   endfunction

   // Single compare process: model expectation against DUT every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [5:0] exp_v;
         int e;
         exp_v = 6'b100000;
         e = edges - m_t0 + 1;
         if (m_mode == 0) begin
            exp_v = {~m_pulse, 5'b00000};
         end else if (m_mode == 2) begin
            exp_v = 6'b000001;
         end else if (e <= RC) begin
            exp_v = 6'b000100;
         end else if (e <= RC + KL) begin
            exp_v = {1'b1, m_key[KL-1-(e-RC-1)], 4'b0100};
         end else begin
            exp_v = {1'b1, user_x, fsm_out, 3'b010};
         end
         total++;
         if (outs() !== exp_v) begin
            bad++;
            $display("FAIL model_cmp t=%0t act=%b exp=%b (obf_rst_n,fsm_x,user_out,busy,unlocked,lockout)",
                     $time, outs(), exp_v);
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int            obf_low;
   int            first_unl;
   logic [KL-1:0] bits;

   initial begin
      cyc();
      cyc();
      @(negedge clk);
      check("reset_outputs", int'(outs()), int'(6'b100000));
      cyc();
      rst_n = 1'b1;

      // Correct key 01110
      key_in = 5'b01110;
      start = 1'b1;
      cyc();
      start = 1'b0;
      key_in = '0;
      obf_low = 0;
      first_unl = 0;
      bits = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (!obf_rst_n) obf_low++;
         if (k >= 3 && k <= 7) bits = {bits[KL-2:0], fsm_x};
         if (unlocked && first_unl == 0) first_unl = k;
         cyc();
      end
      check("obf_low_cycles", obf_low, 2);
      check("shift_bits_01110", int'(bits), int'(5'b01110));
      check("unlock_cycle", first_unl, 8);
      user_x = 1'b1;
      cyc();
      cyc();
      cyc();
      fsm_out = 1'b1;
      @(negedge clk);
      check("user_out_pass", int'(user_out), 1);
      check("fsm_x_follows_user", int'(fsm_x), 1);
      cyc();
      fsm_out = 1'b0;
      user_x = 1'b0;
      relock = 1'b1;
      cyc();
      relock = 1'b0;
      @(negedge clk);
      check("relock_pulse", int'({obf_rst_n, unlocked}), 0);
      cyc();
      @(negedge clk);
      check("idle_after_relock", int'(obf_rst_n), 1);
      cyc();

      // Wrong key 11111 with a start (new key 00000) attempted mid-shift
      key_in = 5'b11111;
      start = 1'b1;
      cyc();
      start = 1'b0;
      bits = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k >= 3 && k <= 7) bits = {bits[KL-2:0], fsm_x};
         if (k == 8) check("wrong_key_unlocked", int'(unlocked), 1);
         cyc();
         if (k == 3) begin
            start = 1'b1;
            key_in = 5'b00000;
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      check("start_in_shift_bits", int'(bits), int'(5'b11111));
      check("wrong_key_user_out", int'(user_out), 0);
      cyc();
      relock = 1'b1;
      cyc();
      relock = 1'b0;
      @(negedge clk);
      check("wrong_relock_pulse", int'(obf_rst_n), 0);
      cyc();

      // Abort on shift cycle 2 (third attempt)
      key_in = 5'b10101;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      cyc();
      cyc();
      relock = 1'b1;
      @(negedge clk);
      check("abort_bit2", int'(fsm_x), 1);
      cyc();
      relock = 1'b0;
      @(negedge clk);
      check("abort_idle", int'({busy, fsm_x, obf_rst_n, unlocked}), 0);
      cyc();

      // Fourth start locks out; start and relock then ignored
      start = 1'b1;
      cyc();
      start = 1'b0;
      @(negedge clk);
      check("lockout_set", int'(lockout), 1);
      check("lockout_obf", int'(obf_rst_n), 0);
      cyc();
      start = 1'b1;
      relock = 1'b1;
      cyc();
      cyc();
      start = 1'b0;
      relock = 1'b0;
      @(negedge clk);
      check("lockout_hold", int'({lockout, obf_rst_n, busy}), int'(3'b100));
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_clears_lockout", int'(outs()), int'(6'b100000));
      cyc();

      // start and relock together in PASS: relock wins
      key_in = 5'b01110;
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (8) cyc();
      @(negedge clk);
      check("prio_in_pass", int'(unlocked), 1);
      cyc();
      start = 1'b1;
      relock = 1'b1;
      cyc();
      start = 1'b0;
      relock = 1'b0;
      @(negedge clk);
      check("prio_relock_wins", int'({busy, unlocked, obf_rst_n}), 0);
      cyc();
      cyc();

      // Reset mid-SHIFT, then the full budget of three attempts is available again
      key_in = 5'b11111;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_mid_shift", int'(outs()), int'(6'b100000));
      cyc();
      cyc();
      for (int a = 1; a <= 3; a++) begin
         key_in = 5'b00001;
         start = 1'b1;
         cyc();
         start = 1'b0;
         @(negedge clk);
         check($sformatf("retry%0d_busy", a), int'(busy), 1);
         relock = 1'b1;
         cyc();
         relock = 1'b0;
         cyc();
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      @(negedge clk);
      check("lockout_after_three", int'(lockout), 1);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
